// File: rtl/distortion_pregain.sv
// Pre-gain ahead of the distortion clamp: sample times a sample-paced ramped gain, shifted and saturated.
// Latency 2 cycles from in_valid to out_valid, one sample per cycle, no backpressure.
module distortion_pregain #(
  parameter int bits_per_level = 12,
  parameter int RAMP_STEP      = 16,
  parameter int OUT_LIMIT      = 32767
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [31:0] in_sample,
  input  logic               gain_load,
  input  logic [15:0]        gain_target,
  output logic               out_valid,
  output logic signed [31:0] out_sample,
  output logic               gain_busy
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [15:0]        UNITY   = 16'(1 << bits_per_level);
  localparam logic [16:0]        STEP    = 17'(RAMP_STEP);
  localparam logic signed [48:0] LIM_POS = 49'(OUT_LIMIT);
  localparam logic signed [48:0] LIM_NEG = -49'(OUT_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] gain_cur;
  logic [15:0] gain_cur_nxt;
  logic [15:0] gain_tgt;
  logic [15:0] gain_tgt_nxt;

  logic        ramp_up;
  logic [16:0] ramp_dist;

  logic               s1_vld;
  logic signed [48:0] s1_dat;
  logic signed [48:0] s2_shift;
  logic signed [48:0] s2_sat;

  // 17-bit distance so neither direction can wrap at the 0 / 0xFFFF ends
  assign ramp_up   = (gain_tgt > gain_cur);
  assign ramp_dist = ramp_up ? ({1'b0, gain_tgt} - {1'b0, gain_cur})
                             : ({1'b0, gain_cur} - {1'b0, gain_tgt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gain_cur  <= UNITY;
      gain_tgt  <= UNITY;
      gain_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      gain_cur  <= gain_cur_nxt;
      gain_tgt  <= gain_tgt_nxt;
      gain_busy <= (state_nxt == RAMP);
    end
  end

  // A coincident load retargets only after this cycle's step against the old target
  always_comb begin
    state_nxt    = state;
    gain_cur_nxt = gain_cur;
    gain_tgt_nxt = gain_tgt;
    if (state == RAMP && in_valid) begin
      if (ramp_dist <= STEP) begin
        gain_cur_nxt = gain_tgt;
        state_nxt    = IDLE;
      end else if (ramp_up) begin
        gain_cur_nxt = gain_cur + STEP[15:0];
      end else begin
        gain_cur_nxt = gain_cur - STEP[15:0];
      end
    end
    if (gain_load) begin
      gain_tgt_nxt = gain_target;
      state_nxt    = (gain_target != gain_cur_nxt) ? RAMP : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_dat <= 49'(in_sample) * 49'($signed({1'b0, gain_cur}));
      end
    end
  end

  assign s2_shift = s1_dat >>> bits_per_level;

  always_comb begin
    s2_sat = s2_shift;
    if (s2_shift > LIM_POS) begin
      s2_sat = LIM_POS;
    end else if (s2_shift < LIM_NEG) begin
      s2_sat = LIM_NEG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_sample <= s2_sat[31:0];
      end
    end
  end

endmodule

// File: tb/tb_distortion_pregain.sv
// Randomized and directed bench for distortion_pregain against a plain-arithmetic gain/ramp model.
module tb_distortion_pregain;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_sample = '0;
  logic               gain_load = 1'b0;
  logic [15:0]        gain_target = '0;
  logic               out_valid;
  logic signed [31:0] out_sample;
  logic               gain_busy;

  distortion_pregain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .gain_load(gain_load), .gain_target(gain_target),
    .out_valid(out_valid), .out_sample(out_sample), .gain_busy(gain_busy)
  );

  always #5 clk = ~clk;

  typedef struct {longint val; int due;} exp_t;
  exp_t   expq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  longint mcur = 4096;
  longint mtgt = 4096;
  bit     mbusy = 1'b0;
  longint last_out = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint model_out(input longint s, input longint g);
    longint p, q;
    p = s * g;
    q = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32767) q = -32767;
    return q;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output checker: timing, value, and hold-while-idle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("out_latency", cyc, e.due);
          chk("out_sample", out_sample, e.val);
        end
        last_out = out_sample;
      end else begin
        chk("hold_out_sample", out_sample, last_out);
        if (expq.size() != 0 && expq[0].due < cyc) begin
          chk("missing_out_valid", expq[0].due, -1);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus with the reference model advanced alongside it
  task automatic drive(input bit v, input int s, input bit l, input int t);
    exp_t e;
    in_valid    = v;
    in_sample   = s;
    gain_load   = l;
    gain_target = t[15:0];
    if (v) begin
      e.val = model_out(longint'(s), mcur);
      e.due = cyc + 2;
      expq.push_back(e);
      if (mbusy) begin
        if (mtgt - mcur <= 16 && mcur - mtgt <= 16) begin
          mcur  = mtgt;
          mbusy = 1'b0;
        end else begin
          mcur = (mtgt > mcur) ? mcur + 16 : mcur - 16;
        end
      end
    end
    if (l) begin
      mtgt  = longint'(t[15:0]);
      mbusy = (mtgt != mcur);
    end
    tick();
    in_valid  = 1'b0;
    gain_load = 1'b0;
    chk("gain_busy", gain_busy, mbusy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_gain_busy", gain_busy, 0);
    expq.delete();
    mcur = 4096; mtgt = 4096; mbusy = 1'b0; last_out = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int s;
    bit v;
    bit l;
    int t;
    tick();
    do_reset();

    // unity
    drive(1, 1000, 0, 0);
    drive(1, -7, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // ramp of +40: gains 4096, 4112, 4128 then settle on 4136
    drive(0, 0, 1, 4136);
    chk("ramp_busy_set", gain_busy, 1);
    drive(1, 4096, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 4096, 0, 0);
    chk("ramp_busy_mid", gain_busy, 1);
    drive(1, 4096, 0, 0);
    chk("ramp_busy_fall", gain_busy, 0);
    drive(1, 4096, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // 8x and saturation
    drive(0, 0, 1, 32'h8000);
    n = 0;
    while (mbusy && n < 5000) begin
      drive(1, int'($urandom_range(2000, 0)) - 1000, 0, 0);
      n++;
    end
    chk("sat_ramp_done", gain_busy, 0);
    drive(1, 5000, 0, 0);
    drive(1, -5000, 0, 0);
    drive(1, -1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // reset with a sample in flight; next sample passes at unity
    do_reset();
    drive(1, 12345, 0, 0);
    rst = 1'b1;
    expq.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("post_rst_busy", gain_busy, 0);
    drive(1, 3333, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // load of mute coinciding with a sample at unity, then 258 samples
    drive(1, 4096, 1, 0);
    for (int i = 0; i < 258; i++) drive(1, 4096, 0, 0);
    chk("mute_busy", gain_busy, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // back-to-back throughput at unity
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, int'($urandom) >>> 12, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // randomized: mid-ramp retargets, reversals, 0 and 0xFFFF targets
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(1, 0) == 1);
      s = int'($urandom) >>> $urandom_range(31, 0);
      l = !v && ($urandom_range(40, 0) == 0);
      case ($urandom_range(3, 0))
        0: t = 0;
        1: t = 16'hFFFF;
        default: t = int'($urandom_range(16'hFFFF, 0));
      endcase
      drive(v, s, l, t);
    end

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    chk("drain_queue", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/distortion_pregain.md
DISTORTION_PREGAIN -- requirements
Module: distortion_pregain

Interface
REQ-001 SHALL have parameter bits_per_level, default 12, fractional bits of the gain word (unity gain = 1 << bits_per_level = 4096).
REQ-002 SHALL have parameter RAMP_STEP, default 16, gain change per accepted sample while ramping.
REQ-003 SHALL have parameter OUT_LIMIT, default 32767, symmetric saturation magnitude of out_sample.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  one-cycle sample strobe at the audio rate.
REQ-007 SHALL have port in_sample  input  32 signed  input sample.
REQ-008 SHALL have port gain_load  input  1  one-cycle strobe that latches gain_target.
REQ-009 SHALL have port gain_target  input  16 unsigned  requested gain, unsigned fixed point with bits_per_level fractional bits.
REQ-010 SHALL have port out_valid  output  1  strobe marking out_sample valid for the distortion clamp stage.
REQ-011 SHALL have port out_sample  output  32 signed  gained, saturated sample.
REQ-012 SHALL have port gain_busy  output  1  high while the state machine is in RAMP.

Function
REQ-013 SHALL hold registers gain_cur (16 bits), gain_tgt (16 bits) and a state machine with states IDLE and RAMP.
REQ-014 SHALL have no backpressure: every in_valid pulse is accepted and produces exactly one out_valid pulse.
REQ-015 SHALL form stage 1 on accept: product = in_sample * gain_cur (signed 32 x unsigned 16 into a 49-bit signed product), registered.
REQ-016 SHALL form stage 2: product arithmetically shifted right by bits_per_level (floor toward minus infinity), saturated to [-OUT_LIMIT, +OUT_LIMIT], registered into out_sample.
REQ-017 SHALL assert out_valid exactly 2 cycles after the accepting in_valid, for one cycle; back-to-back in_valid on consecutive cycles SHALL yield back-to-back out_valid.
REQ-018 SHALL hold out_sample at its last value when out_valid is low.
REQ-019 SHALL multiply each sample by gain_cur as registered before that cycle's edge; any ramp step in the same cycle affects only later samples.
REQ-020 SHALL, on gain_load, register gain_tgt <= gain_target and enter RAMP if gain_target != gain_cur, otherwise go to or remain in IDLE.
REQ-021 SHALL, in RAMP on an accepted sample, move gain_cur toward gain_tgt by RAMP_STEP, landing exactly on gain_tgt when the remaining distance is <= RAMP_STEP (no overshoot), then transition to IDLE on that same edge.
REQ-022 SHALL not step gain_cur in cycles without in_valid; the ramp is paced by samples, not clocks.
REQ-023 SHALL, when gain_load and in_valid coincide, use the old gain_cur for that sample, compare and step against the old gain_tgt in that cycle, and apply the new target from the next cycle on.
REQ-024 SHALL retarget from the current gain_cur when gain_load arrives mid-ramp, including a reversal of direction, without restarting from unity.
REQ-025 SHALL accept gain_target = 0 (mute) and 0xFFFF (about 16x) without wraparound of gain_cur.
REQ-026 SHALL drive gain_busy as a registered decode of state (1 in RAMP).

Reset
REQ-027 SHALL, while rst is high, immediately force state=IDLE, gain_cur=gain_tgt=1<<bits_per_level, both pipeline valid bits=0, out_valid=0, out_sample=0, and gain_busy=0.
REQ-028 SHALL discard samples in flight when rst is asserted mid-operation, so no out_valid appears for them after release.
REQ-029 SHALL accept in_valid on the first rising edge after rst deasserts.

Verification
REQ-030 Unity case: after reset, in_sample=1000 with in_valid -> out_valid 2 cycles later with out_sample=1000; in_sample=-7 -> -7.
REQ-031 Saturation case: gain_load with gain_target=0x8000 (8x), ramp completed, in_sample=5000 -> 32767; in_sample=-5000 -> -32767; in_sample=-1 -> -8.
REQ-032 Ramp case: gain_load with gain_target=4096+40 -> gain_busy=1; samples 1..3 use gain 4096, 4112, 4128; gain_cur then equals 4136 and gain_busy falls on the 3rd sample's edge.
REQ-033 Coincidence case: gain_load(0) in the same cycle as in_valid(in_sample=4096) at unity -> that sample outputs 4096; the next 256 samples step gain down to 0 and then output 0.
REQ-034 Reset case: assert rst one cycle after in_valid -> no out_valid; after release gain_busy=0 and the next sample passes at unity.
REQ-035 Throughput case: in_valid high 10 consecutive cycles at unity -> 10 consecutive out_valid cycles with matching samples in order.
